// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM states, access owner,
// and the widths of the latency and starvation counters.
package unified_mem_arbiter_pkg;

  localparam int LAT_CNT_W = 4;
  localparam int STARVE_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IF,
    OWNER_DM
  } ownerT;

endpackage

// File: rtl/uma_starve_counter.sv
// Saturating count of consecutive data grants taken while a fetch waits;
// sat forces the next contested grant to the fetch side.
module uma_starve_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_W-1:0] cnt;

  assign sat = (cnt == STARVE_W'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter for a single-ported fixed-latency memory, one access in flight.
// Optional UMA_WRITE_POST_EN: data writes complete in their issue cycle.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m
);

  stateT                state, stateNext;
  ownerT                owner, ownerNext;
  logic [LAT_CNT_W-1:0] latCnt, latCntNext;
  logic                 starveSat;
  logic                 grantIf, grantDm, issue, postedWrite;
  logic                 dmDone;

  // Grants are gated by reset so nothing issues while the arbiter is held.
  always_comb begin
    grantIf = 1'b0;
    grantDm = 1'b0;
    if (rst && state == IDLE) begin
      grantDm = dm_req && !(if_req && starveSat);
      grantIf = if_req && !grantDm;
    end
  end

  assign issue = grantIf | grantDm;

`ifdef UMA_WRITE_POST_EN
  assign postedWrite = grantDm & dm_we;
`else
  assign postedWrite = 1'b0;
`endif

  always_comb begin
    stateNext  = state;
    ownerNext  = owner;
    latCntNext = latCnt;
    case (state)
      IDLE: begin
        if (issue && !postedWrite) begin
          ownerNext  = grantDm ? OWNER_DM : OWNER_IF;
          latCntNext = LAT_CNT_W'(MEM_LAT - 1);
          stateNext  = (MEM_LAT == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        latCntNext = latCnt - LAT_CNT_W'(1);
        if (latCntNext == '0) stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
        ownerNext = OWNER_NONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= OWNER_NONE;
      latCnt <= '0;
    end else begin
      state  <= stateNext;
      owner  <= ownerNext;
      latCnt <= latCntNext;
    end
  end

  uma_starve_counter #(
    .MAX(STARVE_MAX)
  ) starveCounter (
    .clk (clk),
    .rst (rst),
    .inc (grantDm & if_req),
    .clr (grantIf | ~if_req),
    .sat (starveSat)
  );

  assign dmDone    = (state == DONE) && (owner == OWNER_DM);
  assign if_gnt    = grantIf;
  assign dm_gnt    = grantDm;
  assign mem_en    = issue;
  assign mem_we    = grantDm & dm_we;
  assign mem_addr  = grantDm ? dm_addr : (grantIf ? if_addr : '0);
  assign mem_wdata = mem_we ? dm_wdata : '0;
  assign if_rvalid = (state == DONE) && (owner == OWNER_IF);
  assign dm_rvalid = dmDone | postedWrite;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dmDone ? mem_rdata : '0;
  assign stall_f   = if_req & ~if_rvalid;
  assign stall_m   = dm_req & ~dm_rvalid;

  // A request that lost arbitration in IDLE must still be there next cycle.
  ifReqHeld: assert property (@(posedge clk) disable iff (!rst)
    (state == IDLE && if_req && !if_gnt) |=> if_req);
  dmReqHeld: assert property (@(posedge clk) disable iff (!rst)
    (state == IDLE && dm_req && !dm_gnt) |=> dm_req);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: MEM_LAT=2 instance for arbitration,
// starvation, write/read and reset; MEM_LAT=1 instance for the fetch loop.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;
  localparam int K_IFGNT = 0, K_IFRV = 1, K_DMGNT = 2, K_DMRV = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
    bit          chk;
  } evT;

  evT expq[2][$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        aIfReq = 1'b0, aIfGnt, aIfRvalid;
  logic [31:0] aIfAddr = '0, aIfRdata;
  logic        aDmReq = 1'b0, aDmWe = 1'b0, aDmGnt, aDmRvalid;
  logic [31:0] aDmAddr = '0, aDmWdata = '0, aDmRdata;
  logic        aMemEn, aMemWe, aStallF, aStallM;
  logic [31:0] aMemAddr, aMemWdata, aMemRdata;

  logic        bIfReq = 1'b0, bIfGnt, bIfRvalid;
  logic [31:0] bIfAddr = '0, bIfRdata;
  logic        bDmReq = 1'b0, bDmWe = 1'b0, bDmGnt, bDmRvalid;
  logic [31:0] bDmAddr = '0, bDmWdata = '0, bDmRdata;
  logic        bMemEn, bMemWe, bStallF, bStallM;
  logic [31:0] bMemAddr, bMemWdata, bMemRdata;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A), .STARVE_MAX(4)) dutA (
    .clk(clk), .rst(rst),
    .if_req(aIfReq), .if_addr(aIfAddr), .if_gnt(aIfGnt), .if_rvalid(aIfRvalid), .if_rdata(aIfRdata),
    .dm_req(aDmReq), .dm_we(aDmWe), .dm_addr(aDmAddr), .dm_wdata(aDmWdata),
    .dm_gnt(aDmGnt), .dm_rvalid(aDmRvalid), .dm_rdata(aDmRdata),
    .mem_en(aMemEn), .mem_we(aMemWe), .mem_addr(aMemAddr), .mem_wdata(aMemWdata),
    .mem_rdata(aMemRdata), .stall_f(aStallF), .stall_m(aStallM));

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B), .STARVE_MAX(4)) dutB (
    .clk(clk), .rst(rst),
    .if_req(bIfReq), .if_addr(bIfAddr), .if_gnt(bIfGnt), .if_rvalid(bIfRvalid), .if_rdata(bIfRdata),
    .dm_req(bDmReq), .dm_we(bDmWe), .dm_addr(bDmAddr), .dm_wdata(bDmWdata),
    .dm_gnt(bDmGnt), .dm_rvalid(bDmRvalid), .dm_rdata(bDmRdata),
    .mem_en(bMemEn), .mem_we(bMemWe), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
    .mem_rdata(bMemRdata), .stall_f(bStallF), .stall_m(bStallM));

  // Memory models: word i initialised to 0xC0DE0000 + i, data returned LAT cycles after issue.
  logic [31:0] memA [256];
  logic [31:0] memB [256];
  logic [31:0] pipeA [LAT_A];
  logic [31:0] pipeB [LAT_B];

  always @(posedge clk) begin
    if (aMemEn && aMemWe) memA[aMemAddr[7:0]] <= aMemWdata;
    pipeA[0] <= aMemEn ? memA[aMemAddr[7:0]] : '0;
    for (int i = 1; i < LAT_A; i++) pipeA[i] <= pipeA[i-1];
    if (bMemEn && bMemWe) memB[bMemAddr[7:0]] <= bMemWdata;
    pipeB[0] <= bMemEn ? memB[bMemAddr[7:0]] : '0;
  end
  assign aMemRdata = pipeA[LAT_A-1];
  assign bMemRdata = pipeB[LAT_B-1];

  function automatic string kindName(int k);
    case (k)
      K_IFGNT: return "if_gnt";
      K_IFRV:  return "if_rvalid";
      K_DMGNT: return "dm_gnt";
      default: return "dm_rvalid";
    endcase
  endfunction

  task automatic push(int d, int kind, int c, logic [31:0] data, bit chk);
    evT e;
    e.kind = kind; e.cyc = c; e.data = data; e.chk = chk;
    expq[d].push_back(e);
  endtask

  task automatic checkEvt(int d, int kind, logic [31:0] data);
    evT e;
    compared++;
    if (expq[d].size() == 0) begin
      mismatched++;
      $display("FAIL dut%0d unexpected %s at cycle %0d data %h, required none", d, kindName(kind), cyc, data);
    end else begin
      e = expq[d].pop_front();
      if (e.kind != kind || e.cyc != cyc || (e.chk && e.data !== data)) begin
        mismatched++;
        $display("FAIL dut%0d event: got %s cycle %0d data %h, required %s cycle %0d data %h",
                 d, kindName(kind), cyc, data, kindName(e.kind), e.cyc, e.data);
      end
    end
  endtask

  // Monitor: gnt events carry mem_addr, rvalid events carry rdata.
  always @(negedge clk) begin
    if (aIfGnt)    checkEvt(0, K_IFGNT, aMemAddr);
    if (aIfRvalid) checkEvt(0, K_IFRV,  aIfRdata);
    if (aDmGnt)    checkEvt(0, K_DMGNT, aMemAddr);
    if (aDmRvalid) checkEvt(0, K_DMRV,  aDmRdata);
    if (bIfGnt)    checkEvt(1, K_IFGNT, bMemAddr);
    if (bIfRvalid) checkEvt(1, K_IFRV,  bIfRdata);
    if (bDmGnt)    checkEvt(1, K_DMGNT, bMemAddr);
    if (bDmRvalid) checkEvt(1, K_DMRV,  bDmRdata);
  end

  task automatic chk32(string name, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic chkBit(string name, logic got, logic exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  // Holds dutA requests until nIf / nDm completions have been seen, then drops them.
  task automatic runA(string name, int nIf, int nDm, int budget);
    int gotIf = 0;
    int gotDm = 0;
    for (int k = 0; k < budget && (aIfReq || aDmReq); k++) begin
      @(negedge clk);
      if (aIfRvalid) gotIf++;
      if (aDmRvalid) gotDm++;
      @(posedge clk); #1;
      if (aIfReq && gotIf >= nIf) aIfReq = 1'b0;
      if (aDmReq && gotDm >= nDm) aDmReq = 1'b0;
    end
    if (aIfReq || aDmReq) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout: got if %0d dm %0d completions, required if %0d dm %0d", name, gotIf, gotDm, nIf, nDm);
      aIfReq = 1'b0;
      aDmReq = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int t, r, n;
    bit seen;
    for (int i = 0; i < 256; i++) begin
      memA[i] = 32'hC0DE0000 + 32'(i);
      memB[i] = 32'hC0DE0000 + 32'(i);
    end
    for (int i = 0; i < LAT_A; i++) pipeA[i] = '0;
    pipeB[0] = '0;

    // Reset: a request held during reset must not be granted.
    aIfReq = 1'b1; aIfAddr = 32'h10;
    @(negedge clk);
    chkBit("reset if_gnt", aIfGnt, 1'b0);
    chkBit("reset mem_en", aMemEn, 1'b0);
    chkBit("reset if_rvalid", aIfRvalid, 1'b0);
    chkBit("reset dm_rvalid", aDmRvalid, 1'b0);
    chk32("reset if_rdata", aIfRdata, 32'h0);
    chkBit("reset dutB if_rvalid", bIfRvalid, 1'b0);
    aIfReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: fetch only
    t = cyc;
    push(0, K_IFGNT, t, 32'h10, 1'b1);
    push(0, K_IFRV, t + 2, 32'hC0DE0010, 1'b1);
    aIfAddr = 32'h10; aIfReq = 1'b1;
    @(negedge clk); chkBit("t1 stall_f c0", aStallF, 1'b1);
    @(negedge clk); chkBit("t1 stall_f c1", aStallF, 1'b1);
    @(negedge clk); chkBit("t1 stall_f c2", aStallF, 1'b0);
    @(posedge clk); #1; aIfReq = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 2: simultaneous requests, data wins
    t = cyc;
    push(0, K_DMGNT, t, 32'h40, 1'b1);
    push(0, K_DMRV, t + 2, 32'hC0DE0040, 1'b1);
    push(0, K_IFGNT, t + 3, 32'h20, 1'b1);
    push(0, K_IFRV, t + 5, 32'hC0DE0020, 1'b1);
    aIfAddr = 32'h20; aIfReq = 1'b1;
    aDmWe = 1'b0; aDmAddr = 32'h40; aDmReq = 1'b1;
    @(negedge clk);
    chkBit("t2 stall_f c0", aStallF, 1'b1);
    chkBit("t2 stall_m c0", aStallM, 1'b1);
    @(posedge clk); #1;
    runA("t2", 1, 1, 20);
    repeat (2) @(posedge clk); #1;

    // 3: starvation limit forces a fetch after four data grants
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      push(0, K_DMGNT, t + 3*i, 32'h44, 1'b1);
      push(0, K_DMRV, t + 3*i + 2, 32'hC0DE0044, 1'b1);
    end
    push(0, K_IFGNT, t + 12, 32'h24, 1'b1);
    push(0, K_IFRV, t + 14, 32'hC0DE0024, 1'b1);
    for (int i = 0; i < 2; i++) begin
      push(0, K_DMGNT, t + 15 + 3*i, 32'h44, 1'b1);
      push(0, K_DMRV, t + 17 + 3*i, 32'hC0DE0044, 1'b1);
    end
    aIfAddr = 32'h24; aIfReq = 1'b1;
    aDmWe = 1'b0; aDmAddr = 32'h44; aDmReq = 1'b1;
    runA("t3", 1, 6, 40);
    repeat (2) @(posedge clk); #1;

    // 4: write then read back
    t = cyc;
    push(0, K_DMGNT, t, 32'h80, 1'b1);
`ifdef UMA_WRITE_POST_EN
    push(0, K_DMRV, t, 32'h0, 1'b0);
`else
    push(0, K_DMRV, t + 2, 32'h0, 1'b0);
`endif
    aDmWe = 1'b1; aDmAddr = 32'h80; aDmWdata = 32'hDEADBEEF; aDmReq = 1'b1;
    runA("t4 write", 0, 1, 20);
    r = cyc;
`ifdef UMA_WRITE_POST_EN
    chk32("t4 read issue offset", 32'(r - t), 32'd1);
`else
    chk32("t4 read issue offset", 32'(r - t), 32'd3);
`endif
    push(0, K_DMGNT, r, 32'h80, 1'b1);
    push(0, K_DMRV, r + 2, 32'hDEADBEEF, 1'b1);
    aDmWe = 1'b0; aDmReq = 1'b1;
    runA("t4 read", 0, 1, 20);
    repeat (2) @(posedge clk); #1;

    // 5: reset while BUSY abandons the access
    t = cyc;
    push(0, K_IFGNT, t, 32'h30, 1'b1);
    aIfAddr = 32'h30; aIfReq = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; aIfReq = 1'b0;
    #1;
    chkBit("t5 if_gnt", aIfGnt, 1'b0);
    chkBit("t5 if_rvalid", aIfRvalid, 1'b0);
    chkBit("t5 dm_gnt", aDmGnt, 1'b0);
    chkBit("t5 dm_rvalid", aDmRvalid, 1'b0);
    chkBit("t5 mem_en", aMemEn, 1'b0);
    chkBit("t5 mem_we", aMemWe, 1'b0);
    chk32("t5 mem_addr", aMemAddr, 32'h0);
    chk32("t5 if_rdata", aIfRdata, 32'h0);
    chk32("t5 dm_rdata", aDmRdata, 32'h0);
    chkBit("t5 stall_f", aStallF, 1'b0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    t = cyc;
    push(0, K_DMGNT, t, 32'h48, 1'b1);
    push(0, K_DMRV, t + 2, 32'hC0DE0048, 1'b1);
    aDmWe = 1'b0; aDmAddr = 32'h48; aDmReq = 1'b1;
    runA("t5 post-reset", 0, 1, 20);
    repeat (2) @(posedge clk); #1;

    // 6: MEM_LAT=1 fetch loop on dutB
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      push(1, K_IFGNT, t + 2*k, 32'(4*k), 1'b1);
      push(1, K_IFRV, t + 2*k + 1, 32'hC0DE0000 + 32'(4*k), 1'b1);
    end
    bIfAddr = 32'h0; bIfReq = 1'b1;
    n = 0;
    for (int k = 0; k < 30 && bIfReq; k++) begin
      @(negedge clk);
      seen = bIfRvalid;
      @(posedge clk); #1;
      if (seen) begin
        n++;
        if (n == 4) bIfReq = 1'b0;
        else bIfAddr = bIfAddr + 32'd4;
      end
    end
    if (bIfReq) begin
      compared++;
      mismatched++;
      $display("FAIL t6 timeout: got %0d fetch completions, required 4", n);
      bIfReq = 1'b0;
    end

    repeat (6) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      while (expq[d].size() > 0) begin
        evT e;
        e = expq[d].pop_front();
        compared++;
        mismatched++;
        $display("FAIL dut%0d missing %s: got none, required at cycle %0d", d, kindName(e.kind), e.cyc);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
